// File: rtl/liteic_pkg.sv
// Shared constants and types for the liteic AXI-Lite interconnect.
package liteic_pkg;

  localparam int unsigned SLICE_BYPASS = 0;
  localparam int unsigned SLICE_LIGHT  = 1;
  localparam int unsigned SLICE_FULL   = 2;

  localparam int unsigned AXI_RESP_WIDTH = 2;
  localparam int unsigned AXI_STRB_WIDTH = 4;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } slice_state_e;

endpackage

// File: rtl/liteic_reg_slice.sv
// Generic valid/ready register slice: bypass, light (single register) or full two-entry skid.
module liteic_reg_slice
  import liteic_pkg::*;
#(
  parameter int unsigned W    = 8,
  parameter int unsigned MODE = SLICE_FULL
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         i_in_valid,
  input  logic [W-1:0] i_in_data,
  output logic         o_in_ready,
  output logic         o_out_valid,
  output logic [W-1:0] o_out_data,
  input  logic         i_out_ready,
  output logic         o_busy
);

  if (MODE == SLICE_BYPASS) begin : g_bypass
    logic w_unused;
    assign w_unused    = clk_i ^ rst_i;
    assign o_out_valid = i_in_valid;
    assign o_out_data  = i_in_data;
    assign o_in_ready  = i_out_ready;
    assign o_busy      = 1'b0;

  end else if (MODE == SLICE_LIGHT) begin : g_light
    logic         r_valid;
    logic         r_ready;
    logic [W-1:0] r_data;

    // r_ready mirrors ~r_valid one cycle late, so push and pop never coincide.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        r_valid <= 1'b0;
        r_ready <= 1'b0;
        r_data  <= '0;
      end else if (i_in_valid && r_ready) begin
        r_valid <= 1'b1;
        r_ready <= 1'b0;
        r_data  <= i_in_data;
      end else if (r_valid && i_out_ready) begin
        r_valid <= 1'b0;
        r_ready <= 1'b1;
      end else begin
        r_ready <= ~r_valid;
      end
    end

    assign o_out_valid = r_valid;
    assign o_out_data  = r_data;
    assign o_in_ready  = r_ready;
    assign o_busy      = r_valid;

  end else begin : g_full
    slice_state_e r_state;
    logic         r_ready;
    logic [W-1:0] r_out;
    logic [W-1:0] r_skid;
    logic         w_push;
    logic         w_pop;

    assign w_push = i_in_valid && r_ready;
    assign w_pop  = (r_state != EMPTY) && i_out_ready;

    // r_ready is registered as (next_state != TWO); default high, cleared on paths into TWO.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        r_state <= EMPTY;
        r_ready <= 1'b0;
        r_out   <= '0;
        r_skid  <= '0;
      end else begin
        r_ready <= 1'b1;
        case (r_state)
          EMPTY: begin
            if (w_push) begin
              r_out   <= i_in_data;
              r_state <= ONE;
            end
          end
          ONE: begin
            if (w_push && !w_pop) begin
              r_skid  <= i_in_data;
              r_state <= TWO;
              r_ready <= 1'b0;
            end else if (w_pop && !w_push) begin
              r_state <= EMPTY;
            end else if (w_push && w_pop) begin
              r_out <= i_in_data;
            end
          end
          TWO: begin
            if (w_pop) begin
              r_out   <= r_skid;
              r_state <= ONE;
            end else begin
              r_ready <= 1'b0;
            end
          end
          default: r_state <= EMPTY;
        endcase
      end
    end

    assign o_out_valid = (r_state != EMPTY);
    assign o_out_data  = r_out;
    assign o_in_ready  = r_ready;
    assign o_busy      = (r_state != EMPTY);
  end

endmodule

// File: rtl/liteic_axil_reg_slice.sv
// AXI-Lite register slice: one independent liteic_reg_slice per channel (AR, AW, W, R, B).
module liteic_axil_reg_slice
  import liteic_pkg::*;
#(
  parameter  int unsigned ADDR_W  = 32,
  parameter  int unsigned DATA_W  = 32,
  parameter  int unsigned QOS_W   = 4,
  parameter  int unsigned RESP_W  = AXI_RESP_WIDTH,
  parameter  int unsigned AR_MODE = SLICE_FULL,
  parameter  int unsigned R_MODE  = SLICE_FULL,
  parameter  int unsigned AW_MODE = SLICE_FULL,
  parameter  int unsigned W_MODE  = SLICE_FULL,
  parameter  int unsigned B_MODE  = SLICE_FULL,
  localparam int unsigned STRB_W  = DATA_W / 8
) (
  input  logic              clk_i,
  input  logic              rst_i,

  input  logic [ADDR_W-1:0] s_ar_addr,
  input  logic [QOS_W-1:0]  s_ar_qos,
  input  logic              s_ar_valid,
  output logic              s_ar_ready,
  output logic [ADDR_W-1:0] m_ar_addr,
  output logic [QOS_W-1:0]  m_ar_qos,
  output logic              m_ar_valid,
  input  logic              m_ar_ready,

  input  logic [ADDR_W-1:0] s_aw_addr,
  input  logic [QOS_W-1:0]  s_aw_qos,
  input  logic              s_aw_valid,
  output logic              s_aw_ready,
  output logic [ADDR_W-1:0] m_aw_addr,
  output logic [QOS_W-1:0]  m_aw_qos,
  output logic              m_aw_valid,
  input  logic              m_aw_ready,

  input  logic [DATA_W-1:0] s_w_data,
  input  logic [STRB_W-1:0] s_w_strb,
  input  logic              s_w_valid,
  output logic              s_w_ready,
  output logic [DATA_W-1:0] m_w_data,
  output logic [STRB_W-1:0] m_w_strb,
  output logic              m_w_valid,
  input  logic              m_w_ready,

  input  logic [DATA_W-1:0] m_r_data,
  input  logic [RESP_W-1:0] m_r_resp,
  input  logic              m_r_valid,
  output logic              m_r_ready,
  output logic [DATA_W-1:0] s_r_data,
  output logic [RESP_W-1:0] s_r_resp,
  output logic              s_r_valid,
  input  logic              s_r_ready,

  input  logic [RESP_W-1:0] m_b_resp,
  input  logic              m_b_valid,
  output logic              m_b_ready,
  output logic [RESP_W-1:0] s_b_resp,
  output logic              s_b_valid,
  input  logic              s_b_ready,

  output logic              busy_o
);

  logic [4:0]               w_busy;
  logic                     r_busy;
  logic [ADDR_W+QOS_W-1:0]  w_ar_out;
  logic [ADDR_W+QOS_W-1:0]  w_aw_out;
  logic [DATA_W+STRB_W-1:0] w_w_out;
  logic [DATA_W+RESP_W-1:0] w_r_out;

  liteic_reg_slice #(.W(ADDR_W + QOS_W), .MODE(AR_MODE)) u_ar (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .i_in_valid  (s_ar_valid),
    .i_in_data   ({s_ar_addr, s_ar_qos}),
    .o_in_ready  (s_ar_ready),
    .o_out_valid (m_ar_valid),
    .o_out_data  (w_ar_out),
    .i_out_ready (m_ar_ready),
    .o_busy      (w_busy[0])
  );
  assign {m_ar_addr, m_ar_qos} = w_ar_out;

  liteic_reg_slice #(.W(ADDR_W + QOS_W), .MODE(AW_MODE)) u_aw (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .i_in_valid  (s_aw_valid),
    .i_in_data   ({s_aw_addr, s_aw_qos}),
    .o_in_ready  (s_aw_ready),
    .o_out_valid (m_aw_valid),
    .o_out_data  (w_aw_out),
    .i_out_ready (m_aw_ready),
    .o_busy      (w_busy[1])
  );
  assign {m_aw_addr, m_aw_qos} = w_aw_out;

  liteic_reg_slice #(.W(DATA_W + STRB_W), .MODE(W_MODE)) u_w (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .i_in_valid  (s_w_valid),
    .i_in_data   ({s_w_data, s_w_strb}),
    .o_in_ready  (s_w_ready),
    .o_out_valid (m_w_valid),
    .o_out_data  (w_w_out),
    .i_out_ready (m_w_ready),
    .o_busy      (w_busy[2])
  );
  assign {m_w_data, m_w_strb} = w_w_out;

  // R and B flow from the downstream (m_) side toward the upstream (s_) side.
  liteic_reg_slice #(.W(DATA_W + RESP_W), .MODE(R_MODE)) u_r (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .i_in_valid  (m_r_valid),
    .i_in_data   ({m_r_data, m_r_resp}),
    .o_in_ready  (m_r_ready),
    .o_out_valid (s_r_valid),
    .o_out_data  (w_r_out),
    .i_out_ready (s_r_ready),
    .o_busy      (w_busy[3])
  );
  assign {s_r_data, s_r_resp} = w_r_out;

  liteic_reg_slice #(.W(RESP_W), .MODE(B_MODE)) u_b (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .i_in_valid  (m_b_valid),
    .i_in_data   (m_b_resp),
    .o_in_ready  (m_b_ready),
    .o_out_valid (s_b_valid),
    .o_out_data  (s_b_resp),
    .i_out_ready (s_b_ready),
    .o_busy      (w_busy[4])
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_busy <= 1'b0;
    else       r_busy <= |w_busy;
  end

  assign busy_o = r_busy;

endmodule

// File: tb/tb_liteic_axil_reg_slice.sv
// Directed bench: dut0 uses full slices everywhere; dut1 has a light AR and a bypass B slice.
module tb_liteic_axil_reg_slice;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  logic [31:0] s_ar_addr, s_aw_addr, s_w_data, m_r_data;
  logic [3:0]  s_ar_qos, s_aw_qos, s_w_strb;
  logic [1:0]  m_r_resp, m_b_resp;
  logic        s_ar_valid, m_ar_ready, s_aw_valid, m_aw_ready, s_w_valid, m_w_ready;
  logic        m_r_valid, s_r_ready, m_b_valid, s_b_ready;

  logic        d0_s_ar_ready, d0_m_ar_valid, d0_s_aw_ready, d0_m_aw_valid, d0_s_w_ready, d0_m_w_valid;
  logic        d0_m_r_ready, d0_s_r_valid, d0_m_b_ready, d0_s_b_valid, d0_busy;
  logic [31:0] d0_m_ar_addr, d0_m_aw_addr, d0_m_w_data, d0_s_r_data;
  logic [3:0]  d0_m_ar_qos, d0_m_aw_qos, d0_m_w_strb;
  logic [1:0]  d0_s_r_resp, d0_s_b_resp;

  logic        d1_s_ar_ready, d1_m_ar_valid, d1_s_aw_ready, d1_m_aw_valid, d1_s_w_ready, d1_m_w_valid;
  logic        d1_m_r_ready, d1_s_r_valid, d1_m_b_ready, d1_s_b_valid, d1_busy;
  logic [31:0] d1_m_ar_addr, d1_m_aw_addr, d1_m_w_data, d1_s_r_data;
  logic [3:0]  d1_m_ar_qos, d1_m_aw_qos, d1_m_w_strb;
  logic [1:0]  d1_s_r_resp, d1_s_b_resp;

  int checks = 0;
  int errors = 0;

  liteic_axil_reg_slice #(
    .AR_MODE(2), .R_MODE(2), .AW_MODE(2), .W_MODE(2), .B_MODE(2)
  ) dut0 (
    .clk_i(clk), .rst_i(rst),
    .s_ar_addr(s_ar_addr), .s_ar_qos(s_ar_qos), .s_ar_valid(s_ar_valid), .s_ar_ready(d0_s_ar_ready),
    .m_ar_addr(d0_m_ar_addr), .m_ar_qos(d0_m_ar_qos), .m_ar_valid(d0_m_ar_valid), .m_ar_ready(m_ar_ready),
    .s_aw_addr(s_aw_addr), .s_aw_qos(s_aw_qos), .s_aw_valid(s_aw_valid), .s_aw_ready(d0_s_aw_ready),
    .m_aw_addr(d0_m_aw_addr), .m_aw_qos(d0_m_aw_qos), .m_aw_valid(d0_m_aw_valid), .m_aw_ready(m_aw_ready),
    .s_w_data(s_w_data), .s_w_strb(s_w_strb), .s_w_valid(s_w_valid), .s_w_ready(d0_s_w_ready),
    .m_w_data(d0_m_w_data), .m_w_strb(d0_m_w_strb), .m_w_valid(d0_m_w_valid), .m_w_ready(m_w_ready),
    .m_r_data(m_r_data), .m_r_resp(m_r_resp), .m_r_valid(m_r_valid), .m_r_ready(d0_m_r_ready),
    .s_r_data(d0_s_r_data), .s_r_resp(d0_s_r_resp), .s_r_valid(d0_s_r_valid), .s_r_ready(s_r_ready),
    .m_b_resp(m_b_resp), .m_b_valid(m_b_valid), .m_b_ready(d0_m_b_ready),
    .s_b_resp(d0_s_b_resp), .s_b_valid(d0_s_b_valid), .s_b_ready(s_b_ready),
    .busy_o(d0_busy)
  );

  liteic_axil_reg_slice #(
    .AR_MODE(1), .R_MODE(2), .AW_MODE(2), .W_MODE(2), .B_MODE(0)
  ) dut1 (
    .clk_i(clk), .rst_i(rst),
    .s_ar_addr(s_ar_addr), .s_ar_qos(s_ar_qos), .s_ar_valid(s_ar_valid), .s_ar_ready(d1_s_ar_ready),
    .m_ar_addr(d1_m_ar_addr), .m_ar_qos(d1_m_ar_qos), .m_ar_valid(d1_m_ar_valid), .m_ar_ready(m_ar_ready),
    .s_aw_addr(s_aw_addr), .s_aw_qos(s_aw_qos), .s_aw_valid(s_aw_valid), .s_aw_ready(d1_s_aw_ready),
    .m_aw_addr(d1_m_aw_addr), .m_aw_qos(d1_m_aw_qos), .m_aw_valid(d1_m_aw_valid), .m_aw_ready(m_aw_ready),
    .s_w_data(s_w_data), .s_w_strb(s_w_strb), .s_w_valid(s_w_valid), .s_w_ready(d1_s_w_ready),
    .m_w_data(d1_m_w_data), .m_w_strb(d1_m_w_strb), .m_w_valid(d1_m_w_valid), .m_w_ready(m_w_ready),
    .m_r_data(m_r_data), .m_r_resp(m_r_resp), .m_r_valid(m_r_valid), .m_r_ready(d1_m_r_ready),
    .s_r_data(d1_s_r_data), .s_r_resp(d1_s_r_resp), .s_r_valid(d1_s_r_valid), .s_r_ready(s_r_ready),
    .m_b_resp(m_b_resp), .m_b_valid(m_b_valid), .m_b_ready(d1_m_b_ready),
    .s_b_resp(d1_s_b_resp), .s_b_valid(d1_s_b_valid), .s_b_ready(s_b_ready),
    .busy_o(d1_busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    s_ar_addr = '0; s_ar_qos = '0; s_ar_valid = 1'b0; m_ar_ready = 1'b0;
    s_aw_addr = '0; s_aw_qos = '0; s_aw_valid = 1'b0; m_aw_ready = 1'b0;
    s_w_data = '0; s_w_strb = '0; s_w_valid = 1'b0; m_w_ready = 1'b0;
    m_r_data = '0; m_r_resp = '0; m_r_valid = 1'b0; s_r_ready = 1'b0;
    m_b_resp = '0; m_b_valid = 1'b0; s_b_ready = 1'b0;
    repeat (3) step();
    checks++;
    if ({d0_m_ar_valid, d0_m_aw_valid, d0_m_w_valid, d0_s_r_valid, d0_s_b_valid, d1_m_ar_valid} !== 6'b0) begin
      errors++;
      $display("FAIL reset_valids: got %b expected 000000",
               {d0_m_ar_valid, d0_m_aw_valid, d0_m_w_valid, d0_s_r_valid, d0_s_b_valid, d1_m_ar_valid});
    end
    checks++;
    if ({d0_s_ar_ready, d0_s_aw_ready, d0_s_w_ready, d0_m_r_ready, d0_m_b_ready, d1_s_ar_ready} !== 6'b0) begin
      errors++;
      $display("FAIL reset_readies: got %b expected 000000",
               {d0_s_ar_ready, d0_s_aw_ready, d0_s_w_ready, d0_m_r_ready, d0_m_b_ready, d1_s_ar_ready});
    end
    checks++;
    if ({d0_busy, d1_busy} !== 2'b00) begin
      errors++;
      $display("FAIL reset_busy: got %b expected 00", {d0_busy, d1_busy});
    end
    checks++;
    if (d0_m_w_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_payload: got %h expected 00000000", d0_m_w_data);
    end
    rst = 1'b0;
    #2;
    checks++;
    if (d0_s_ar_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_before_edge: got %b expected 0", d0_s_ar_ready);
    end
    step();
    checks++;
    if ({d0_s_ar_ready, d0_s_aw_ready, d0_s_w_ready, d0_m_r_ready, d0_m_b_ready, d1_s_ar_ready} !== 6'b111111) begin
      errors++;
      $display("FAIL ready_after_release: got %b expected 111111",
               {d0_s_ar_ready, d0_s_aw_ready, d0_s_w_ready, d0_m_r_ready, d0_m_b_ready, d1_s_ar_ready});
    end
  endtask

  task automatic test_ar_stream();
    m_ar_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s_ar_valid = 1'b1;
      s_ar_addr  = 32'h1000 + 32'(i) * 32'h10;
      s_ar_qos   = 4'(i);
      step();
      checks++;
      if (d0_m_ar_valid !== 1'b1 || d0_m_ar_addr !== 32'h1000 + 32'(i) * 32'h10 ||
          d0_m_ar_qos !== 4'(i) || d0_s_ar_ready !== 1'b1) begin
        errors++;
        $display("FAIL ar_stream[%0d]: got v=%b addr=%h qos=%h rdy=%b expected v=1 addr=%h qos=%h rdy=1",
                 i, d0_m_ar_valid, d0_m_ar_addr, d0_m_ar_qos, d0_s_ar_ready,
                 32'h1000 + 32'(i) * 32'h10, 4'(i));
      end
    end
    s_ar_valid = 1'b0;
    step();
    checks++;
    if (d0_m_ar_valid !== 1'b0) begin
      errors++;
      $display("FAIL ar_stream_drain: got valid=%b expected 0", d0_m_ar_valid);
    end
    step();
  endtask

  task automatic test_w_backpressure();
    logic [31:0] got [0:3];
    logic [31:0] exp_w [0:2];
    int n = 0;
    exp_w[0] = 32'hA; exp_w[1] = 32'hB; exp_w[2] = 32'hC;
    m_w_ready = 1'b0;
    s_w_strb  = 4'hF;
    s_w_valid = 1'b1;
    s_w_data  = 32'hA;
    step();
    checks++;
    if (d0_s_w_ready !== 1'b1) begin
      errors++;
      $display("FAIL w_ready_after_1: got %b expected 1", d0_s_w_ready);
    end
    s_w_data = 32'hB;
    step();
    checks++;
    if (d0_s_w_ready !== 1'b0 || d0_m_w_data !== 32'hA) begin
      errors++;
      $display("FAIL w_ready_after_2: got rdy=%b data=%h expected rdy=0 data=0000000a", d0_s_w_ready, d0_m_w_data);
    end
    s_w_data = 32'hC;
    step();
    checks++;
    if (d0_m_w_valid !== 1'b1 || d0_m_w_data !== 32'hA || d0_s_w_ready !== 1'b0 || d0_m_w_strb !== 4'hF) begin
      errors++;
      $display("FAIL w_stall_hold: got v=%b data=%h strb=%h rdy=%b expected v=1 data=0000000a strb=f rdy=0",
               d0_m_w_valid, d0_m_w_data, d0_m_w_strb, d0_s_w_ready);
    end
    m_w_ready = 1'b1;
    for (int cyc = 0; cyc < 8; cyc++) begin
      automatic logic acc = s_w_valid && d0_s_w_ready;
      if (d0_m_w_valid && m_w_ready) begin
        if (n < 4) got[n] = d0_m_w_data;
        n++;
      end
      step();
      if (acc) s_w_valid = 1'b0;
    end
    checks++;
    if (n != 3) begin
      errors++;
      $display("FAIL w_beat_count: got %0d expected 3", n);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i < n && got[i] !== exp_w[i]) begin
        errors++;
        $display("FAIL w_order[%0d]: got %h expected %h", i, got[i], exp_w[i]);
      end
    end
  endtask

  task automatic test_light_ar();
    int k_in = 0;
    int k_out = 0;
    int toggle_bad = 0;
    logic prev;
    m_ar_ready = 1'b1;
    s_ar_valid = 1'b1;
    s_ar_addr  = 32'h2000;
    prev = d1_s_ar_ready;
    for (int cyc = 0; cyc < 10; cyc++) begin
      automatic logic acc = s_ar_valid && d1_s_ar_ready;
      if (d1_m_ar_valid && m_ar_ready) begin
        checks++;
        if (d1_m_ar_addr !== 32'h2000 + 32'(k_out) * 32'h10) begin
          errors++;
          $display("FAIL light_addr[%0d]: got %h expected %h", k_out, d1_m_ar_addr,
                   32'h2000 + 32'(k_out) * 32'h10);
        end
        k_out++;
      end
      step();
      if (acc) begin
        k_in++;
        s_ar_addr = 32'h2000 + 32'(k_in) * 32'h10;
      end
      if (d1_s_ar_ready === prev) toggle_bad++;
      prev = d1_s_ar_ready;
    end
    checks++;
    if (k_out != 5) begin
      errors++;
      $display("FAIL light_rate: got %0d transfers in 10 cycles expected 5", k_out);
    end
    checks++;
    if (toggle_bad != 0) begin
      errors++;
      $display("FAIL light_ready_toggle: got %0d non-toggling cycles expected 0", toggle_bad);
    end
    s_ar_valid = 1'b0;
    step();
    step();
  endtask

  task automatic test_b_bypass();
    m_b_resp  = 2'b10;
    m_b_valid = 1'b1;
    s_b_ready = 1'b0;
    #1;
    checks++;
    if (d1_s_b_resp !== 2'b10 || d1_s_b_valid !== 1'b1) begin
      errors++;
      $display("FAIL b_bypass_fwd: got resp=%b valid=%b expected resp=10 valid=1", d1_s_b_resp, d1_s_b_valid);
    end
    checks++;
    if (d1_m_b_ready !== 1'b0) begin
      errors++;
      $display("FAIL b_bypass_ready_low: got %b expected 0", d1_m_b_ready);
    end
    s_b_ready = 1'b1;
    #1;
    checks++;
    if (d1_m_b_ready !== 1'b1) begin
      errors++;
      $display("FAIL b_bypass_ready_high: got %b expected 1", d1_m_b_ready);
    end
    step();
    m_b_valid = 1'b0;
    step();
    step();
  endtask

  task automatic test_mid_reset();
    int stale = 0;
    m_w_ready = 1'b0;
    s_w_valid = 1'b1;
    s_w_data  = 32'h55;
    step();
    s_w_data  = 32'h66;
    step();
    s_w_valid = 1'b0;
    checks++;
    if (d0_m_w_valid !== 1'b1 || d0_m_w_data !== 32'h55 || d0_s_w_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_full: got v=%b data=%h rdy=%b expected v=1 data=00000055 rdy=0",
               d0_m_w_valid, d0_m_w_data, d0_s_w_ready);
    end
    checks++;
    if (d0_busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_busy_set: got %b expected 1", d0_busy);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (d0_m_w_valid !== 1'b0 || d0_s_w_ready !== 1'b0 || d0_busy !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got v=%b rdy=%b busy=%b expected 0 0 0", d0_m_w_valid, d0_s_w_ready, d0_busy);
    end
    step();
    rst = 1'b0;
    m_w_ready = 1'b1;
    for (int cyc = 0; cyc < 6; cyc++) begin
      if (d0_m_w_valid) stale++;
      step();
    end
    checks++;
    if (stale != 0) begin
      errors++;
      $display("FAIL no_stale_beat: got %0d valid cycles expected 0", stale);
    end
    checks++;
    if (d0_busy !== 1'b0 || d0_s_w_ready !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_state: got busy=%b rdy=%b expected busy=0 rdy=1", d0_busy, d0_s_w_ready);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_ar_stream();
    test_w_backpressure();
    test_light_ar();
    test_b_bypass();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
